// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sequencing controller for the endless-mode stopwatch.
// Owns four BCD time digits (ss.cc) and steps them through IDLE/RUN/PAUSE/DONE
// under one-cycle game-control pulses and a 100 Hz tick.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tick              one-cycle centisecond enable
//   level             current game level; timing only while == ENDLESS_LEVEL
//   start/stop/pause  one-cycle control pulses
//   sec_ten..msec_uni registered BCD digits (0-9 each)
//   running, done     registered state flags (RUN / DONE)
module stopwatch_ctrl #(
  parameter logic [1:0] ENDLESS_LEVEL = 2'd3,
  parameter bit         STOP_AT_MAX   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] level,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  output logic [3:0] sec_ten,
  output logic [3:0] sec_uni,
  output logic [3:0] msec_ten,
  output logic [3:0] msec_uni,
  output logic       running,
  output logic       done
);

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] DIGIT_ONE = DIGIT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] st;
    logic [DIGIT_W-1:0] su;
    logic [DIGIT_W-1:0] mt;
    logic [DIGIT_W-1:0] mu;
  } time_t;

  state_t state_q, state_d;
  time_t  time_q, time_d;
  logic   running_d, done_d;
  logic   at_max;

  // BCD ripple increment; each digit wraps 9 -> 0 and carries upward.
  function automatic time_t bcd_inc(input time_t t);
    time_t r;
    r = t;
    if (t.mu != DIGIT_MAX) begin
      r.mu = t.mu + DIGIT_ONE;
    end else begin
      r.mu = '0;
      if (t.mt != DIGIT_MAX) begin
        r.mt = t.mt + DIGIT_ONE;
      end else begin
        r.mt = '0;
        if (t.su != DIGIT_MAX) begin
          r.su = t.su + DIGIT_ONE;
        end else begin
          r.su = '0;
          r.st = (t.st != DIGIT_MAX) ? t.st + DIGIT_ONE : '0;
        end
      end
    end
    return r;
  endfunction

  assign at_max = (time_q.st == DIGIT_MAX) && (time_q.su == DIGIT_MAX) &&
                  (time_q.mt == DIGIT_MAX) && (time_q.mu == DIGIT_MAX);

  // State, digits and flags register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      time_q  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      running <= running_d;
      done    <= done_d;
    end
  end

  // Next state / next digits; priority level-exit > start > stop > pause > tick
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    if (level != ENDLESS_LEVEL) begin
      state_d = IDLE;
      time_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            time_d  = '0;
          end
        end
        RUN: begin
          if (start) begin
            time_d = '0;
          end else if (stop) begin
            state_d = DONE;
          end else if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (at_max && STOP_AT_MAX) begin
              state_d = DONE;
            end else begin
              time_d = bcd_inc(time_q);
            end
          end
        end
        PAUSE: begin
          if (start) begin
            state_d = RUN;
            time_d  = '0;
          end else if (stop) begin
            state_d = DONE;
          end else if (pause) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (start) begin
            state_d = RUN;
            time_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          time_d  = '0;
        end
      endcase
    end
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  assign sec_ten  = time_q.st;
  assign sec_uni  = time_q.su;
  assign msec_ten = time_q.mt;
  assign msec_uni = time_q.mu;

endmodule
